// File: rtl/mc_control_if.sv
// ============================================================================
//  Module   : mc_control_if
//  Purpose  : Control/status bundle between the multicycle controller and the
//             16-bit datapath (opcode, flags, memory handshake, all selects).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface mc_control_if #(
  parameter int OP_W    = 4,
  parameter int STATE_W = 4
);
  logic [OP_W-1:0]    op;
  logic               zero;
  logic               mem_ready;

  logic               IRWrite;
  logic               PCWrite;
  logic               PCWriteCond;
  logic               AWrite;
  logic               BWrite;
  logic               ALUOutWrite;
  logic               MDWrite;
  logic               RegWrite;
  logic               MemRead;
  logic               MemWrite;
  logic               ReadAddr;
  logic [1:0]         ALUA;
  logic [1:0]         ALUB;
  logic [2:0]         ALUControl;
  logic [1:0]         PCSource;
  logic               RegDest;
  logic               MemToReg;
  logic               illegal_op;
  logic [STATE_W-1:0] state;

  modport master (
    input  op, zero, mem_ready,
    output IRWrite, PCWrite, PCWriteCond, AWrite, BWrite, ALUOutWrite,
           MDWrite, RegWrite, MemRead, MemWrite, ReadAddr, ALUA, ALUB,
           ALUControl, PCSource, RegDest, MemToReg, illegal_op, state
  );

  modport slave (
    output op, zero, mem_ready,
    input  IRWrite, PCWrite, PCWriteCond, AWrite, BWrite, ALUOutWrite,
           MDWrite, RegWrite, MemRead, MemWrite, ReadAddr, ALUA, ALUB,
           ALUControl, PCSource, RegDest, MemToReg, illegal_op, state
  );
endinterface

`default_nettype wire

// File: rtl/mc_control_fsm.sv
// ============================================================================
//  Module   : mc_control_fsm
//  Purpose  : Multicycle fetch/decode/execute/writeback controller with memory
//             ready handshake, branch qualifier, immediate ALU path and trap.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mc_control_fsm #(
  parameter int OP_W        = 4,
  parameter int TRAP_ENABLE = 1,
  parameter int STATE_W     = 4
) (
  input  wire logic      clk,
  input  wire logic      rst,
  mc_control_if.master   ctrl_if
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_R_EXEC   = 4'd2,
    S_R_WB     = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_LW_RD    = 4'd5,
    S_LW_WB    = 4'd6,
    S_SW_WR    = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwcond;
    logic       awrite;
    logic       bwrite;
    logic       aluowrite;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       readaddr;
    logic [1:0] alua;
    logic [1:0] alub;
    logic [2:0] aluc;
    logic [1:0] pcsrc;
    logic       regdest;
    logic       memtoreg;
  } ctl_t;

  // Moore portion of the control word for a given state.
  function automatic ctl_t f_decode(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.memread = 1'b1; c.alub = 2'd1; c.aluc = 3'd1; end
      S_DECODE:   begin c.awrite = 1'b1; c.bwrite = 1'b1; end
      S_R_EXEC:   begin c.alua = 2'd1; c.aluowrite = 1'b1; end
      S_R_WB:     begin c.regwrite = 1'b1; end
      S_MEM_ADDR, S_I_EXEC:
                  begin c.alua = 2'd1; c.alub = 2'd2; c.aluc = 3'd1; c.aluowrite = 1'b1; end
      S_LW_RD:    begin c.memread = 1'b1; c.readaddr = 1'b1; end
      S_LW_WB:    begin c.regwrite = 1'b1; c.regdest = 1'b1; c.memtoreg = 1'b1; end
      S_SW_WR:    begin c.memwrite = 1'b1; c.readaddr = 1'b1; end
      S_BRANCH:   begin c.alua = 2'd1; c.aluc = 3'd2; c.pcwcond = 1'b1; c.pcsrc = 2'd1; end
      S_JUMP:     begin c.pcwrite = 1'b1; c.pcsrc = 2'd2; end
      S_I_WB:     begin c.regwrite = 1'b1; c.regdest = 1'b1; end
      S_TRAP:     begin c.pcwrite = 1'b1; c.pcsrc = 2'd3; end
      default:    c = '0;
    endcase
    return c;
  endfunction

  logic [OP_W-1:0] w_op;
  logic [3:0]      w_op_lo;
  logic            w_hi_nz;
  logic            w_illegal;
  logic            w_rdy;
  logic            w_run;
  logic            w_fetch;
  state_t          w_next;

  state_t          r_state;
  ctl_t            r_ctl;
  logic            r_illegal;

  assign w_op    = ctrl_if.op;
  assign w_op_lo = w_op[3:0];
  assign w_rdy   = ctrl_if.mem_ready;

  generate
    if (OP_W > 4) begin : g_op_hi
      assign w_hi_nz = |w_op[OP_W-1:4];
    end else begin : g_op_narrow
      assign w_hi_nz = 1'b0;
    end
  endgenerate

  assign w_illegal = w_hi_nz | (w_op_lo > 4'd5);

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = w_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (w_illegal) begin
          w_next = (TRAP_ENABLE != 0) ? S_TRAP : S_FETCH;
        end else begin
          case (w_op_lo)
            4'd0:       w_next = S_R_EXEC;
            4'd1, 4'd2: w_next = S_MEM_ADDR;
            4'd3:       w_next = S_BRANCH;
            4'd4:       w_next = S_JUMP;
            4'd5:       w_next = S_I_EXEC;
            default:    w_next = S_FETCH;
          endcase
        end
      end
      S_R_EXEC:   w_next = S_R_WB;
      S_MEM_ADDR: w_next = (w_op == OP_W'(1)) ? S_LW_RD : S_SW_WR;
      S_LW_RD:    w_next = w_rdy ? S_LW_WB : S_LW_RD;
      S_SW_WR:    w_next = w_rdy ? S_FETCH : S_SW_WR;
      S_I_EXEC:   w_next = S_I_WB;
      default:    w_next = S_FETCH;
    endcase
  end

  // Selects leave reset already holding the FETCH word so the first fetch is
  // not delayed; enables and strobes are separately masked while rst is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_ctl     <= f_decode(S_FETCH);
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ctl   <= f_decode(w_next);
      if (r_state == S_DECODE && w_illegal) begin
        r_illegal <= 1'b1;
      end
    end
  end

  assign w_run   = ~rst;
  assign w_fetch = (r_state == S_FETCH);

  assign ctrl_if.IRWrite     = w_run & w_fetch & w_rdy;
  assign ctrl_if.PCWrite     = w_run & (r_ctl.pcwrite | (w_fetch & w_rdy));
  assign ctrl_if.PCWriteCond = w_run & r_ctl.pcwcond;
  assign ctrl_if.AWrite      = w_run & r_ctl.awrite;
  assign ctrl_if.BWrite      = w_run & r_ctl.bwrite;
  assign ctrl_if.ALUOutWrite = w_run & r_ctl.aluowrite;
  assign ctrl_if.MDWrite     = w_run & (r_state == S_LW_RD) & w_rdy;
  assign ctrl_if.RegWrite    = w_run & r_ctl.regwrite;
  assign ctrl_if.MemRead     = w_run & r_ctl.memread;
  assign ctrl_if.MemWrite    = w_run & r_ctl.memwrite;
  assign ctrl_if.ReadAddr    = r_ctl.readaddr;
  assign ctrl_if.ALUA        = r_ctl.alua;
  assign ctrl_if.ALUB        = r_ctl.alub;
  assign ctrl_if.ALUControl  = r_ctl.aluc;
  assign ctrl_if.PCSource    = r_ctl.pcsrc;
  assign ctrl_if.RegDest     = r_ctl.regdest;
  assign ctrl_if.MemToReg    = r_ctl.memtoreg;
  assign ctrl_if.illegal_op  = r_illegal;
  assign ctrl_if.state       = STATE_W'(r_state);

endmodule

`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
// ============================================================================
//  Module   : tb_mc_control_fsm
//  Purpose  : Self-checking bench for mc_control_fsm (directed vectors, random
//             instruction stream against a path-level model, corner sequences).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mc_control_fsm;

  logic clk;
  logic rst;

  mc_control_if #(.OP_W(4), .STATE_W(4)) a_if ();
  mc_control_if #(.OP_W(4), .STATE_W(4)) nt_if ();
  mc_control_if #(.OP_W(6), .STATE_W(5)) w6_if ();

  mc_control_fsm #(.OP_W(4), .TRAP_ENABLE(1), .STATE_W(4)) u_dut (
    .clk(clk), .rst(rst), .ctrl_if(a_if));
  mc_control_fsm #(.OP_W(4), .TRAP_ENABLE(0), .STATE_W(4)) u_dut_nt (
    .clk(clk), .rst(rst), .ctrl_if(nt_if));
  mc_control_fsm #(.OP_W(6), .TRAP_ENABLE(1), .STATE_W(5)) u_dut_w6 (
    .clk(clk), .rst(rst), .ctrl_if(w6_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       irw, pcw, pcwc, aw, bw, aluow, mdw, rw, mr, mw, ra;
    logic [1:0] alua;
    logic [1:0] alub;
    logic [2:0] aluc;
    logic [1:0] pcs;
    logic       rd, m2r;
  } outs_t;

  typedef struct {
    logic [3:0] op;
    logic       z, r;
    int         st;
    logic       irw, mdw, rw, mw, pcwc;
    logic [1:0] pcs;
    logic       ill;
  } vec_t;

  int    n_chk  = 0;
  int    n_pass = 0;
  outs_t tab [13];
  vec_t  vt [$];

  // Model: queue of states the current instruction still has to visit.
  int    q [$];
  bit    m_ill;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endfunction

  function automatic outs_t grab();
    outs_t o;
    o.irw = a_if.IRWrite;   o.pcw = a_if.PCWrite;     o.pcwc = a_if.PCWriteCond;
    o.aw  = a_if.AWrite;    o.bw  = a_if.BWrite;      o.aluow = a_if.ALUOutWrite;
    o.mdw = a_if.MDWrite;   o.rw  = a_if.RegWrite;    o.mr = a_if.MemRead;
    o.mw  = a_if.MemWrite;  o.ra  = a_if.ReadAddr;    o.alua = a_if.ALUA;
    o.alub = a_if.ALUB;     o.aluc = a_if.ALUControl; o.pcs = a_if.PCSource;
    o.rd  = a_if.RegDest;   o.m2r = a_if.MemToReg;
    return o;
  endfunction

  function automatic vec_t v(logic [3:0] op, logic z, logic r, int st, logic irw,
                             logic mdw, logic rw, logic mw, logic pcwc,
                             logic [1:0] pcs, logic ill);
    vec_t e;
    e.op = op; e.z = z; e.r = r; e.st = st; e.irw = irw; e.mdw = mdw;
    e.rw = rw; e.mw = mw; e.pcwc = pcwc; e.pcs = pcs; e.ill = ill;
    return e;
  endfunction

  function automatic void model_reset();
    q.delete();
    q.push_back(0);
    m_ill = 1'b0;
  endfunction

  function automatic void model_adv(int op, bit rdy);
    int cur;
    cur = q[0];
    if ((cur == 0 || cur == 5 || cur == 7) && !rdy) return;
    void'(q.pop_front());
    if (cur == 0) q.push_back(1);
    else if (cur == 1) begin
      case (op)
        0: begin q.push_back(2); q.push_back(3); end
        1: begin q.push_back(4); q.push_back(5); q.push_back(6); end
        2: begin q.push_back(4); q.push_back(7); end
        3: q.push_back(8);
        4: q.push_back(9);
        5: begin q.push_back(10); q.push_back(11); end
        default: begin m_ill = 1'b1; q.push_back(12); end
      endcase
    end
    if (q.size() == 0) q.push_back(0);
  endfunction

  task automatic drive_and_check(input logic [3:0] op, input logic z, input logic r);
    outs_t e;
    a_if.op = op; a_if.zero = z; a_if.mem_ready = r;
    @(negedge clk);
    e = tab[q[0]];
    if (q[0] == 0) begin e.irw = r; e.pcw = r; end
    if (q[0] == 5) e.mdw = r;
    chk("model_state", 32'(a_if.state), 32'(q[0]));
    chk("model_outs", 32'(grab()), 32'(e));
    chk("model_illegal", 32'(a_if.illegal_op), 32'(m_ill));
  endtask

  task automatic advance(input int op, input logic r);
    model_adv(op, r);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_if.mem_ready = 1'b1; a_if.op = '0;
    @(negedge clk);
    chk("rst_irwrite", 32'(a_if.IRWrite), 32'd0);
    chk("rst_pcwrite", 32'(a_if.PCWrite), 32'd0);
    chk("rst_memread", 32'(a_if.MemRead), 32'd0);
    chk("rst_state", 32'(a_if.state), 32'd0);
    chk("rst_illegal", 32'(a_if.illegal_op), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int op_hold;
    logic z, r;
    vec_t e;

    foreach (tab[i]) tab[i] = '0;
    tab[0].mr = 1; tab[0].alub = 2'd1; tab[0].aluc = 3'd1;
    tab[1].aw = 1; tab[1].bw = 1;
    tab[2].alua = 2'd1; tab[2].aluow = 1;
    tab[3].rw = 1;
    tab[4].alua = 2'd1; tab[4].alub = 2'd2; tab[4].aluc = 3'd1; tab[4].aluow = 1;
    tab[5].mr = 1; tab[5].ra = 1;
    tab[6].rw = 1; tab[6].rd = 1; tab[6].m2r = 1;
    tab[7].mw = 1; tab[7].ra = 1;
    tab[8].alua = 2'd1; tab[8].aluc = 3'd2; tab[8].pcwc = 1; tab[8].pcs = 2'd1;
    tab[9].pcw = 1; tab[9].pcs = 2'd2;
    tab[10] = tab[4];
    tab[11].rw = 1; tab[11].rd = 1;
    tab[12].pcw = 1; tab[12].pcs = 2'd3;

    //            op z r st irw mdw rw mw pcwc pcs ill
    vt.push_back(v(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));   // R-type
    vt.push_back(v(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(v(0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(v(0, 0, 1, 3, 0, 0, 1, 0, 0, 0, 0));
    vt.push_back(v(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));   // LW, 3 read waits
    vt.push_back(v(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(v(1, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(v(1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(v(1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(v(1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(v(1, 0, 1, 5, 0, 1, 0, 0, 0, 0, 0));
    vt.push_back(v(1, 0, 1, 6, 0, 0, 1, 0, 0, 0, 0));
    vt.push_back(v(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));   // SW, 2 fetch waits
    vt.push_back(v(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(v(2, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    vt.push_back(v(2, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(v(2, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(v(2, 0, 0, 7, 0, 0, 0, 1, 0, 0, 0));
    vt.push_back(v(2, 0, 0, 7, 0, 0, 0, 1, 0, 0, 0));
    vt.push_back(v(2, 0, 1, 7, 0, 0, 0, 1, 0, 0, 0));
    vt.push_back(v(3, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));   // branch, zero=0
    vt.push_back(v(3, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(v(3, 0, 1, 8, 0, 0, 0, 0, 1, 1, 0));
    vt.push_back(v(3, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0));   // branch, zero=1
    vt.push_back(v(3, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(v(3, 1, 1, 8, 0, 0, 0, 0, 1, 1, 0));
    vt.push_back(v(7, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));   // illegal -> trap
    vt.push_back(v(7, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(v(7, 0, 1, 12, 0, 0, 0, 0, 0, 3, 1));
    vt.push_back(v(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1));   // sticky flag
    vt.push_back(v(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1));
    vt.push_back(v(0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 1));

    rst = 1'b1;
    a_if.op = '0;  a_if.zero = 1'b0;  a_if.mem_ready = 1'b1;
    nt_if.op = '0; nt_if.zero = 1'b0; nt_if.mem_ready = 1'b1;
    w6_if.op = '0; w6_if.zero = 1'b0; w6_if.mem_ready = 1'b1;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    for (int i = 0; i < vt.size(); i++) begin
      e = vt[i];
      drive_and_check(e.op, e.z, e.r);
      chk($sformatf("vec%0d_state", i), 32'(a_if.state), 32'(e.st));
      chk($sformatf("vec%0d_flags", i),
          32'({a_if.IRWrite, a_if.MDWrite, a_if.RegWrite, a_if.MemWrite,
               a_if.PCWriteCond, a_if.PCSource, a_if.illegal_op}),
          32'({e.irw, e.mdw, e.rw, e.mw, e.pcwc, e.pcs, e.ill}));
      advance(int'(e.op), e.r);
    end

    do_reset();
    op_hold = 0;
    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset();
      if (q[0] == 0) op_hold = int'($urandom_range(0, 8));
      z = 1'($urandom % 2);
      r = (($urandom % 4) != 0);
      drive_and_check(4'(op_hold), z, r);
      advance(op_hold, r);
    end

    // TRAP_ENABLE=0: illegal opcode is skipped straight back to fetch.
    do_reset();
    nt_if.op = 4'd7; nt_if.mem_ready = 1'b1;
    @(negedge clk); chk("nt_fetch", 32'(nt_if.state), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("nt_decode", 32'(nt_if.state), 32'd1);
    chk("nt_ill_pre", 32'(nt_if.illegal_op), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("nt_back_fetch", 32'(nt_if.state), 32'd0);
    chk("nt_ill_set", 32'(nt_if.illegal_op), 32'd1);
    @(posedge clk); #1;
    @(negedge clk); chk("nt_ill_sticky", 32'(nt_if.illegal_op), 32'd1);
    @(posedge clk); #1;

    // OP_W=6: high opcode bits make op illegal; async reset during SW_WR.
    do_reset();
    w6_if.op = 6'h10; w6_if.mem_ready = 1'b1;
    @(negedge clk); chk("w6_fetch", 32'(w6_if.state), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("w6_decode", 32'(w6_if.state), 32'd1);
    @(posedge clk); #1;
    @(negedge clk); chk("w6_trap", 32'(w6_if.state), 32'd12);
    chk("w6_trap_pcsrc", 32'(w6_if.PCSource), 32'd3);
    chk("w6_trap_pcw", 32'(w6_if.PCWrite), 32'd1);
    chk("w6_trap_ill", 32'(w6_if.illegal_op), 32'd1);
    @(posedge clk); #1;
    @(negedge clk); chk("w6_trap_ret", 32'(w6_if.state), 32'd0);
    w6_if.op = 6'h02;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    w6_if.mem_ready = 1'b0;
    @(negedge clk); chk("w6_sw_state", 32'(w6_if.state), 32'd7);
    chk("w6_sw_memwrite", 32'(w6_if.MemWrite), 32'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("w6_rst_memwrite", 32'(w6_if.MemWrite), 32'd0);
    chk("w6_rst_state", 32'(w6_if.state), 32'd0);
    chk("w6_rst_ill", 32'(w6_if.illegal_op), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk); chk("w6_post_state", 32'(w6_if.state), 32'd0);
    chk("w6_post_memread", 32'(w6_if.MemRead), 32'd1);
    chk("w6_post_memwrite", 32'(w6_if.MemWrite), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
